// File: rtl/emb_update.sv
// Embedding-layer SGD optimizer: sweeps weight and gradient RAMs in lock-step,
// writes w - (g >>> LR_SHIFT) back with saturation and clears each gradient word.
module emb_update #(
    parameter int ADDR_WIDTH = 10,
    parameter int LR_SHIFT   = 4,
    parameter int DATA_N     = 4,
    parameter int N_LEN      = 16,
    parameter int N_LEN_W    = 24,
    parameter int CHAR_NUM   = 64,
    parameter int EMB_DIM    = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        run,
    output logic                        valid,
    output logic [ADDR_WIDTH-1:0]       grad_raddr,
    input  logic [DATA_N*N_LEN_W-1:0]   grad_rdata,
    output logic [ADDR_WIDTH-1:0]       grad_waddr,
    output logic [DATA_N*N_LEN_W-1:0]   grad_wdata,
    output logic                        grad_we,
    output logic [ADDR_WIDTH-1:0]       w_raddr,
    input  logic [DATA_N*N_LEN-1:0]     w_rdata,
    output logic [ADDR_WIDTH-1:0]       w_waddr,
    output logic [DATA_N*N_LEN-1:0]     w_wdata,
    output logic                        w_we
);

    localparam int WORDS = CHAR_NUM * EMB_DIM / DATA_N;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(WORDS - 1);
    localparam logic signed [N_LEN_W:0] SAT_MAX =
        $signed({{(N_LEN_W + 2 - N_LEN){1'b0}}, {(N_LEN - 1){1'b1}}});
    localparam logic signed [N_LEN_W:0] SAT_MIN =
        $signed({{(N_LEN_W + 2 - N_LEN){1'b1}}, {(N_LEN - 1){1'b0}}});

    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

    state_t                      state_q;
    logic [ADDR_WIDTH-1:0]       raddr_q;
    logic                        rd_v_q;      // a read was issued at the last edge
    logic [ADDR_WIDTH-1:0]       rd_addr_q;
    logic                        drain_q;
    logic                        s1_v_q;
    logic [ADDR_WIDTH-1:0]       s1_addr_q;
    logic [DATA_N*N_LEN-1:0]     s1_w_q;
    logic [DATA_N*N_LEN_W-1:0]   s1_g_q;
    logic                        s2_v_q;
    logic [ADDR_WIDTH-1:0]       s2_addr_q;
    logic [DATA_N*N_LEN-1:0]     s2_wdata_q;
    logic [DATA_N*N_LEN-1:0]     upd_d;

    genvar gi;
    generate
        for (gi = 0; gi < DATA_N; gi++) begin : g_lane
            logic signed [N_LEN-1:0]   w_lane;
            logic signed [N_LEN_W-1:0] g_val;
            logic signed [N_LEN_W-1:0] d_lane;
            logic signed [N_LEN_W:0]   w_ext;
            logic signed [N_LEN_W:0]   d_ext;
            logic signed [N_LEN_W:0]   t_lane;

            assign w_lane = s1_w_q[gi*N_LEN +: N_LEN];
            assign g_val  = s1_g_q[gi*N_LEN_W +: N_LEN_W];
            // Arithmetic shift floors negative gradients toward -inf.
            assign d_lane = g_val >>> LR_SHIFT;
            assign w_ext  = {{(N_LEN_W + 1 - N_LEN){w_lane[N_LEN-1]}}, w_lane};
            assign d_ext  = {d_lane[N_LEN_W-1], d_lane};
            assign t_lane = w_ext - d_ext;
            assign upd_d[gi*N_LEN +: N_LEN] =
                (t_lane > SAT_MAX) ? SAT_MAX[N_LEN-1:0] :
                (t_lane < SAT_MIN) ? SAT_MIN[N_LEN-1:0] :
                                     t_lane[N_LEN-1:0];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            raddr_q    <= '0;
            rd_v_q     <= 1'b0;
            rd_addr_q  <= '0;
            drain_q    <= 1'b0;
            s1_v_q     <= 1'b0;
            s1_addr_q  <= '0;
            s1_w_q     <= '0;
            s1_g_q     <= '0;
            s2_v_q     <= 1'b0;
            s2_addr_q  <= '0;
            s2_wdata_q <= '0;
        end else if (!run) begin
            state_q <= IDLE;
            raddr_q <= '0;
            rd_v_q  <= 1'b0;
            drain_q <= 1'b0;
            s1_v_q  <= 1'b0;
            s2_v_q  <= 1'b0;
        end else begin
            s1_v_q    <= rd_v_q;
            s1_addr_q <= rd_addr_q;
            s1_w_q    <= w_rdata;
            s1_g_q    <= grad_rdata;
            s2_v_q    <= s1_v_q;
            if (s1_v_q) begin
                s2_addr_q  <= s1_addr_q;
                s2_wdata_q <= upd_d;
            end

            case (state_q)
                IDLE, READ: begin
                    // Leave READ one edge after the last address was sampled.
                    if (state_q == READ && rd_v_q && rd_addr_q == LAST_ADDR) begin
                        rd_v_q  <= 1'b0;
                        drain_q <= 1'b0;
                        state_q <= DRAIN;
                    end else begin
                        rd_v_q    <= 1'b1;
                        rd_addr_q <= raddr_q;
                        if (raddr_q != LAST_ADDR) begin
                            raddr_q <= raddr_q + 1'b1;
                        end
                        state_q <= READ;
                    end
                end
                DRAIN: begin
                    rd_v_q  <= 1'b0;
                    drain_q <= 1'b1;
                    if (drain_q) begin
                        state_q <= DONE;
                    end
                end
                default: begin
                    rd_v_q <= 1'b0;
                end
            endcase
        end
    end

    assign valid      = run & (state_q == DONE);
    assign grad_raddr = raddr_q;
    assign w_raddr    = raddr_q;
    assign grad_waddr = s2_addr_q;
    assign w_waddr    = s2_addr_q;
    assign w_wdata    = s2_wdata_q;
    assign grad_wdata = '0;
    assign grad_we    = run & s2_v_q;
    assign w_we       = run & s2_v_q;

endmodule

// File: tb/tb_emb_update.sv
// Bench for emb_update: behavioural RAMs plus a floor-division SGD reference model.
module tb_emb_update;

    localparam int AW    = 5;
    localparam int LR    = 4;
    localparam int DN    = 4;
    localparam int NL    = 16;
    localparam int NW    = 24;
    localparam int CN    = 8;
    localparam int ED    = 8;
    localparam int WORDS = CN * ED / DN;
    localparam int WMAX  = (1 << (NL - 1)) - 1;
    localparam int WMIN  = -(1 << (NL - 1));
    localparam int DEPTH = 1 << AW;

    logic              clk = 1'b0;
    logic              rst;
    logic              run;
    logic              valid;
    logic [AW-1:0]     grad_raddr, grad_waddr, w_raddr, w_waddr;
    logic [DN*NW-1:0]  grad_rdata, grad_wdata;
    logic [DN*NL-1:0]  w_rdata, w_wdata;
    logic              grad_we, w_we;

    logic [DN*NL-1:0]  w_mem  [DEPTH];
    logic [DN*NW-1:0]  g_mem  [DEPTH];
    logic [DN*NL-1:0]  orig_w [WORDS];
    logic [DN*NW-1:0]  orig_g [WORDS];
    logic              ld_en;
    logic [AW-1:0]     ld_addr;
    logic [DN*NL-1:0]  ld_w;
    logic [DN*NW-1:0]  ld_g;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    emb_update #(
        .ADDR_WIDTH(AW), .LR_SHIFT(LR), .DATA_N(DN), .N_LEN(NL),
        .N_LEN_W(NW), .CHAR_NUM(CN), .EMB_DIM(ED)
    ) dut (
        .clk(clk), .rst(rst), .run(run), .valid(valid),
        .grad_raddr(grad_raddr), .grad_rdata(grad_rdata),
        .grad_waddr(grad_waddr), .grad_wdata(grad_wdata), .grad_we(grad_we),
        .w_raddr(w_raddr), .w_rdata(w_rdata),
        .w_waddr(w_waddr), .w_wdata(w_wdata), .w_we(w_we)
    );

    // Synchronous-read RAMs with a bench-side load port.
    always @(posedge clk) begin
        w_rdata    <= w_mem[w_raddr];
        grad_rdata <= g_mem[grad_raddr];
        if (ld_en) begin
            w_mem[ld_addr] <= ld_w;
            g_mem[ld_addr] <= ld_g;
        end else begin
            if (w_we)    w_mem[w_waddr]    <= w_wdata;
            if (grad_we) g_mem[grad_waddr] <= grad_wdata;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_w(input int a, input int l, input int v);
        logic [NL-1:0] t;
        t = v[NL-1:0];
        orig_w[a][l*NL +: NL] = t;
    endtask

    task automatic set_g(input int a, input int l, input int v);
        logic [NW-1:0] t;
        t = v[NW-1:0];
        orig_g[a][l*NW +: NW] = t;
    endtask

    function automatic int lane_w(input int a, input int l);
        logic signed [NL-1:0] t;
        t = orig_w[a][l*NL +: NL];
        return int'(t);
    endfunction

    function automatic int lane_g(input int a, input int l);
        logic signed [NW-1:0] t;
        t = orig_g[a][l*NW +: NW];
        return int'(t);
    endfunction

    // floor(g / 2^LR), then clamp w - d to the weight range
    function automatic int upd(input int w, input int g);
        int d, t, s;
        s = 1 << LR;
        if (g >= 0) d = g / s;
        else        d = -((-g + s - 1) / s);
        t = w - d;
        if (t > WMAX) t = WMAX;
        if (t < WMIN) t = WMIN;
        return t;
    endfunction

    function automatic logic [DN*NL-1:0] exp_w(input int a);
        logic [DN*NL-1:0] r;
        int t;
        r = '0;
        for (int l = 0; l < DN; l++) begin
            t = upd(lane_w(a, l), lane_g(a, l));
            r[l*NL +: NL] = t[NL-1:0];
        end
        return r;
    endfunction

    task automatic fill_random;
        for (int a = 0; a < WORDS; a++) begin
            for (int l = 0; l < DN; l++) begin
                set_w(a, l, int'($urandom_range(0, 65535)) - 32768);
                if ($urandom_range(0, 1) == 1)
                    set_g(a, l, int'($urandom_range(0, 8191)) - 4096);
                else
                    set_g(a, l, int'($urandom_range(0, (1 << NW) - 1)) - (1 << (NW - 1)));
            end
        end
    endtask

    task automatic load_all;
        for (int a = 0; a < WORDS; a++) begin
            ld_en   = 1'b1;
            ld_addr = AW'(a);
            ld_w    = orig_w[a];
            ld_g    = orig_g[a];
            tick;
        end
        ld_en = 1'b0;
        tick;
    endtask

    // Drives run high; next edge is cycle 0. Records write count, first valid cycle,
    // and address-ordering anomalies.
    task automatic run_sweep(output int wr_cnt, output int valid_cyc, output int bad);
        int hist[$];
        logic [AW-1:0] ra;
        wr_cnt = 0; valid_cyc = -1; bad = 0;
        run = 1'b1;
        for (int c = 0; c < WORDS + 8 && valid_cyc < 0; c++) begin
            ra = w_raddr;
            tick;
            hist.push_back(int'(ra));
            if (c < WORDS && int'(ra) != c) bad++;
            if (grad_raddr !== w_raddr || grad_waddr !== w_waddr ||
                grad_we !== w_we || grad_wdata !== '0) bad++;
            if (w_we === 1'b1) begin
                wr_cnt++;
                $display("write cycle=%0d addr=%0d data=%h", c, w_waddr, w_wdata);
                if (c < 2) bad++;
                else if (int'(w_waddr) != hist[c-2]) bad++;
            end
            if (valid === 1'b1) valid_cyc = c;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; run = 1'b0; ld_en = 1'b0;
        tick; tick;
        run = 1'b1;
        for (int k = 0; k < 2; k++) begin
            tick;
            checks++;
            if (w_raddr !== '0 || grad_raddr !== '0 || w_waddr !== '0 || grad_waddr !== '0) begin
                errors++;
                $display("FAIL reset_addr: got r=%h/%h w=%h/%h expected 0", w_raddr, grad_raddr, w_waddr, grad_waddr);
            end
            checks++;
            if (w_wdata !== '0 || grad_wdata !== '0 || w_we !== 1'b0 || grad_we !== 1'b0 || valid !== 1'b0) begin
                errors++;
                $display("FAIL reset_data: got wd=%h gd=%h we=%b/%b valid=%b expected 0", w_wdata, grad_wdata, w_we, grad_we, valid);
            end
        end
        run = 1'b0; rst = 1'b0;
        tick;
    endtask

    task automatic test_full_sweep;
        int wc, vc, bad;
        logic [DN*NL-1:0] e;
        for (int a = 0; a < WORDS; a++)
            for (int l = 0; l < DN; l++) begin set_w(a, l, 100); set_g(a, l, 32); end
        load_all;
        run_sweep(wc, vc, bad);
        checks++;
        if (wc != WORDS) begin errors++; $display("FAIL full_writes: got %0d expected %0d", wc, WORDS); end
        checks++;
        if (vc != WORDS + 2) begin errors++; $display("FAIL full_valid_cycle: got %0d expected %0d", vc, WORDS + 2); end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL full_addr: got %0d anomalies expected 0", bad); end
        run = 1'b0;
        #1;
        checks++;
        if (valid !== 1'b0) begin errors++; $display("FAIL full_valid_fall: got %b expected 0", valid); end
        tick;
        e = {DN{16'd98}};
        for (int a = 0; a < WORDS; a++) begin
            checks++;
            if (w_mem[a] !== e) begin errors++; $display("FAIL full_w[%0d]: got %h expected %h", a, w_mem[a], e); end
            checks++;
            if (g_mem[a] !== '0) begin errors++; $display("FAIL full_g[%0d]: got %h expected 0", a, g_mem[a]); end
        end
    endtask

    task automatic test_rounding;
        int wc, vc, bad;
        logic [DN*NL-1:0] e;
        for (int a = 0; a < WORDS; a++) begin
            set_w(a, 0, 100); set_g(a, 0, -17);
            set_w(a, 1, 0);   set_g(a, 1, -1);
            set_w(a, 2, -5);  set_g(a, 2, 17);
            set_w(a, 3, 7);   set_g(a, 3, -16);
        end
        load_all;
        run_sweep(wc, vc, bad);
        run = 1'b0;
        tick;
        e = {16'd8, 16'hfffa, 16'd1, 16'd102};
        for (int a = 0; a < WORDS; a++) begin
            checks++;
            if (w_mem[a] !== e) begin errors++; $display("FAIL round_w[%0d]: got %h expected %h", a, w_mem[a], e); end
        end
    endtask

    task automatic test_saturation;
        int wc, vc, bad;
        logic [DN*NL-1:0] e;
        for (int a = 0; a < WORDS; a++) begin
            set_w(a, 0, WMAX); set_g(a, 0, -(1 << (NW - 1)));
            set_w(a, 1, WMIN); set_g(a, 1, (1 << (NW - 1)) - 1);
            set_w(a, 2, WMAX); set_g(a, 2, -16);
            set_w(a, 3, WMIN); set_g(a, 3, 16);
        end
        load_all;
        run_sweep(wc, vc, bad);
        run = 1'b0;
        tick;
        e = {16'h8000, 16'h7fff, 16'h8000, 16'h7fff};
        for (int a = 0; a < WORDS; a++) begin
            checks++;
            if (w_mem[a] !== e) begin errors++; $display("FAIL sat_w[%0d]: got %h expected %h", a, w_mem[a], e); end
        end
    endtask

    task automatic test_address;
        int wc, vc, bad;
        for (int a = 0; a < WORDS; a++)
            for (int l = 0; l < DN; l++) begin set_w(a, l, a); set_g(a, l, 16 * a); end
        load_all;
        run_sweep(wc, vc, bad);
        checks++;
        if (bad != 0) begin errors++; $display("FAIL addr_order: got %0d anomalies expected 0", bad); end
        checks++;
        if (wc != WORDS) begin errors++; $display("FAIL addr_writes: got %0d expected %0d", wc, WORDS); end
        run = 1'b0;
        tick;
        for (int a = 0; a < WORDS; a++) begin
            checks++;
            if (w_mem[a] !== '0) begin errors++; $display("FAIL addr_w[%0d]: got %h expected 0", a, w_mem[a]); end
        end
    endtask

    task automatic test_random;
        int wc, vc, bad;
        for (int rep = 0; rep < 2; rep++) begin
            fill_random;
            load_all;
            run_sweep(wc, vc, bad);
            run = 1'b0;
            tick;
            for (int a = 0; a < WORDS; a++) begin
                checks++;
                if (w_mem[a] !== exp_w(a)) begin errors++; $display("FAIL rand_w[%0d]: got %h expected %h", a, w_mem[a], exp_w(a)); end
                checks++;
                if (g_mem[a] !== '0) begin errors++; $display("FAIL rand_g[%0d]: got %h expected 0", a, g_mem[a]); end
            end
        end
    endtask

    task automatic test_abort;
        int wc, vc, bad;
        logic [DN*NL-1:0] ew;
        logic [DN*NW-1:0] eg;
        fill_random;
        load_all;
        run = 1'b1;
        for (int c = 0; c <= 10; c++) tick;
        checks++;
        if (w_we !== 1'b1 || int'(w_waddr) != 8) begin errors++; $display("FAIL abort_pre: got we=%b addr=%0d expected we=1 addr=8", w_we, w_waddr); end
        run = 1'b0;
        #1;
        checks++;
        if (w_we !== 1'b0 || grad_we !== 1'b0 || valid !== 1'b0) begin errors++; $display("FAIL abort_we: got we=%b/%b valid=%b expected 0", w_we, grad_we, valid); end
        tick;
        checks++;
        if (w_raddr !== '0 || w_we !== 1'b0) begin errors++; $display("FAIL abort_idle: got raddr=%0d we=%b expected 0", w_raddr, w_we); end
        for (int a = 0; a < WORDS; a++) begin
            ew = (a < 8) ? exp_w(a) : orig_w[a];
            eg = (a < 8) ? '0 : orig_g[a];
            checks++;
            if (w_mem[a] !== ew || g_mem[a] !== eg) begin errors++; $display("FAIL abort_mem[%0d]: got %h/%h expected %h/%h", a, w_mem[a], g_mem[a], ew, eg); end
        end
        run_sweep(wc, vc, bad);
        checks++;
        if (vc != WORDS + 2) begin errors++; $display("FAIL abort_restart_valid: got %0d expected %0d", vc, WORDS + 2); end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL abort_restart_addr: got %0d anomalies expected 0", bad); end
        run = 1'b0;
        tick;
        for (int a = 0; a < WORDS; a++) begin
            checks++;
            if (w_mem[a] !== exp_w(a)) begin errors++; $display("FAIL abort_final[%0d]: got %h expected %h", a, w_mem[a], exp_w(a)); end
        end
    endtask

    task automatic test_reset_mid;
        int wc, vc, bad;
        fill_random;
        load_all;
        run = 1'b1;
        for (int c = 0; c <= 5; c++) tick;
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            tick;
            checks++;
            if (w_we !== 1'b0 || grad_we !== 1'b0 || valid !== 1'b0 || w_raddr !== '0 ||
                w_waddr !== '0 || w_wdata !== '0) begin
                errors++;
                $display("FAIL rst_mid_outputs: got we=%b valid=%b raddr=%0d waddr=%0d wdata=%h expected 0", w_we, valid, w_raddr, w_waddr, w_wdata);
            end
        end
        rst = 1'b0;
        run_sweep(wc, vc, bad);
        checks++;
        if (vc != WORDS + 2) begin errors++; $display("FAIL rst_mid_valid: got %0d expected %0d", vc, WORDS + 2); end
        checks++;
        if (bad != 0 || wc != WORDS) begin errors++; $display("FAIL rst_mid_sweep: got anomalies=%0d writes=%0d expected 0/%0d", bad, wc, WORDS); end
        run = 1'b0;
        tick;
        for (int a = 0; a < WORDS; a++) begin
            checks++;
            if (w_mem[a] !== exp_w(a) || g_mem[a] !== '0) begin errors++; $display("FAIL rst_mid_mem[%0d]: got %h/%h expected %h/0", a, w_mem[a], g_mem[a], exp_w(a)); end
        end
    endtask

    initial begin
        rst = 1'b1; run = 1'b0; ld_en = 1'b0; ld_addr = '0; ld_w = '0; ld_g = '0;
        test_reset;
        test_full_sweep;
        test_rounding;
        test_saturation;
        test_address;
        test_random;
        test_abort;
        test_reset_mid;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
